// File: rtl/sprite_arb_pkg.sv
// Shared defaults and types for the sprite ROM arbiter.
package sprite_arb_pkg;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_ADDR_W   = 12;
   localparam int DEF_DATA_W   = 5;
   localparam int DEF_MAX_WAIT = 64;
   localparam int WAIT_W       = 8;

   typedef logic [$clog2(DEF_N_REQ)-1:0] req_id_t;
   typedef logic [DEF_ADDR_W-1:0]        rom_addr_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM side bundle of the sprite ROM arbiter.
interface sprite_rom_arbiter_if
   import sprite_arb_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic [N_REQ-1:0]             req;
   logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0]             gnt;
   logic [ADDR_W-1:0]            rom_address;
   logic [DATA_W-1:0]            rom_q;
   logic [N_REQ-1:0]             rsp_valid;
   logic [DATA_W-1:0]            rsp_data;
   logic [N_REQ-1:0]             starved;
   logic                         clr_starved;

   modport master (
      output req, req_addr, rom_q, clr_starved,
      input  gnt, rom_address, rsp_valid, rsp_data, starved
   );

   modport slave (
      input  req, req_addr, rom_q, clr_starved,
      output gnt, rom_address, rsp_valid, rsp_data, starved
   );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin first-set finder: first request at or
// after ptr_i, wrapping from N-1 to 0.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!valid_o && req_i[i] && IDX_W'(i) >= ptr_i) begin
            valid_o  = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = IDX_W'(i);
         end
      end
      // second pass covers the wrapped-around part below the pointer
      for (int i = 0; i < N; i++) begin
         if (!valid_o && req_i[i] && IDX_W'(i) < ptr_i) begin
            valid_o  = 1'b1;
            gnt_o[i] = 1'b1;
            idx_o    = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: requester 0 has absolute priority, the rest
// share round-robin; tracks wait time and flags starvation.
module sprite_rom_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input logic                 vga_clk,
   input logic                 reset_n,
   sprite_rom_arbiter_if.slave arb_if
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] SAT_W = '1;

   logic [N_REQ-1:0]           lp_req;
   logic [N_REQ-1:0]           lp_gnt;
   logic [IDX_W-1:0]           lp_idx;
   logic                       lp_valid;
   logic [N_REQ-1:0]           gnt;
   logic [ADDR_W-1:0]          rom_addr;
   logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:1][WAIT_W-1:0] wait_q, wait_d;
   logic [N_REQ-1:0]           starved_q, starved_d;
   logic [N_REQ-1:0]           rsp_valid_q;

   // bit 0 is masked so the finder's wrap to 0 behaves as a wrap to 1
   assign lp_req = {arb_if.req[N_REQ-1:1], 1'b0};

   rr_pick #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (lp_req),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (lp_gnt),
      .idx_o   (lp_idx),
      .valid_o (lp_valid)
   );

   always_comb begin
      gnt = '0;
      if (arb_if.req[0]) begin
         gnt[0] = 1'b1;
      end else begin
         gnt = lp_gnt;
      end
   end

   always_comb begin
      rom_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            rom_addr = rom_addr | arb_if.req_addr[i];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (!arb_if.req[0] && lp_valid) begin
         if (lp_idx == IDX_W'(N_REQ - 1)) begin
            rr_ptr_d = IDX_W'(1);
         end else begin
            rr_ptr_d = lp_idx + 1'b1;
         end
      end
   end

   always_comb begin
      wait_d    = '0;
      starved_d = '0;
      for (int i = 1; i < N_REQ; i++) begin
         if (arb_if.req[i] && !gnt[i]) begin
            wait_d[i] = (wait_q[i] == SAT_W) ? SAT_W : wait_q[i] + 1'b1;
         end
         // a fresh threshold hit beats a simultaneous clear
         if (wait_d[i] >= MAX_W) begin
            starved_d[i] = 1'b1;
         end else if (arb_if.clr_starved) begin
            starved_d[i] = 1'b0;
         end else begin
            starved_d[i] = starved_q[i];
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q    <= IDX_W'(1);
         wait_q      <= '0;
         starved_q   <= '0;
         rsp_valid_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         wait_q      <= wait_d;
         starved_q   <= starved_d;
         rsp_valid_q <= gnt;
      end
   end

   assign arb_if.gnt         = gnt;
   assign arb_if.rom_address = rom_addr;
   assign arb_if.rsp_valid   = rsp_valid_q;
   assign arb_if.rsp_data    = arb_if.rom_q;
   assign arb_if.starved     = starved_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter with a negedge ROM model.
module tb_sprite_rom_arbiter;
   import sprite_arb_pkg::*;

   localparam int N  = 4;
   localparam int AW = 12;
   localparam int DW = 5;
   localparam int MW = 8;

   typedef struct {
      logic [N-1:0]  v;
      logic [DW-1:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   pass_n = 0;
   int   tot_n  = 0;
   exp_t sb[$];
   rom_addr_t addr_tbl[N];

   always #5 clk = ~clk;

   sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sprite_rom_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)
   ) dut (
      .vga_clk (clk),
      .reset_n (rst_n),
      .arb_if  (bus.slave)
   );

   function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
      return a[4:0] ^ a[9:5] ^ {3'b000, a[11:10]} ^ 5'h13;
   endfunction

   always @(negedge clk) bus.rom_q <= rom_fn(bus.rom_address);

   function automatic int idx_of(input logic [N-1:0] g);
      int r;
      r = 0;
      for (int i = 0; i < N; i++) if (g[i]) r = i;
      return r;
   endfunction

   task automatic load_addrs;
      for (int i = 0; i < N; i++) begin
         addr_tbl[i] = rom_addr_t'(12'h123 + 12'h2C7 * i);
         bus.req_addr[i] = addr_tbl[i];
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.req = '0;
      bus.clr_starved = 1'b0;
      load_addrs();
      #12 rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         tot_n++;
         if (bus.gnt !== 4'b0000)
            $display("FAIL reset_gnt c%0d got %b want 0000", c, bus.gnt);
         else pass_n++;
         tot_n++;
         if (bus.rom_address !== 12'h000)
            $display("FAIL reset_addr c%0d got %h want 000", c, bus.rom_address);
         else pass_n++;
         tot_n++;
         if (bus.rsp_valid !== 4'b0000)
            $display("FAIL reset_rspv c%0d got %b want 0000", c, bus.rsp_valid);
         else pass_n++;
         tot_n++;
         if (bus.starved !== 4'b0000)
            $display("FAIL reset_starved c%0d got %b want 0000", c, bus.starved);
         else pass_n++;
      end
   endtask

   task automatic test_round_robin;
      logic [N-1:0] pat[6];
      logic [N-1:0] eg[6];
      exp_t e;
      pat = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110};
      eg  = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
      for (int c = 0; c < 6; c++) begin
         bus.req = pat[c];
         #1;
         tot_n++;
         if (bus.gnt !== eg[c])
            $display("FAIL rr_gnt c%0d got %b want %b", c, bus.gnt, eg[c]);
         else pass_n++;
         tot_n++;
         if (bus.rom_address !== addr_tbl[idx_of(eg[c])])
            $display("FAIL rr_addr c%0d got %h want %h", c,
                     bus.rom_address, addr_tbl[idx_of(eg[c])]);
         else pass_n++;
         sb.push_back('{v: eg[c], d: rom_fn(addr_tbl[idx_of(eg[c])])});
         @(posedge clk); #1;
         e = sb.pop_front();
         tot_n++;
         if (bus.rsp_valid !== e.v)
            $display("FAIL rr_rspv c%0d got %b want %b", c, bus.rsp_valid, e.v);
         else pass_n++;
         tot_n++;
         if (bus.rsp_data !== e.d)
            $display("FAIL rr_data c%0d got %h want %h", c, bus.rsp_data, e.d);
         else pass_n++;
      end
      bus.req = '0;
   endtask

   task automatic test_single;
      exp_t e;
      addr_tbl[2] = 12'h0A5;
      bus.req_addr[2] = 12'h0A5;
      bus.req = 4'b0100;
      #1;
      tot_n++;
      if (bus.gnt !== 4'b0100)
         $display("FAIL single_gnt got %b want 0100", bus.gnt);
      else pass_n++;
      tot_n++;
      if (bus.rom_address !== 12'h0A5)
         $display("FAIL single_addr got %h want 0a5", bus.rom_address);
      else pass_n++;
      sb.push_back('{v: 4'b0100, d: rom_fn(12'h0A5)});
      @(posedge clk); #1;
      bus.req = '0;
      e = sb.pop_front();
      tot_n++;
      if (bus.rsp_valid !== e.v)
         $display("FAIL single_rspv got %b want %b", bus.rsp_valid, e.v);
      else pass_n++;
      tot_n++;
      if (bus.rsp_data !== e.d)
         $display("FAIL single_data got %h want %h", bus.rsp_data, e.d);
      else pass_n++;
      sb.push_back('{v: 4'b0000, d: '0});
      @(posedge clk); #1;
      e = sb.pop_front();
      tot_n++;
      if (bus.rsp_valid !== e.v)
         $display("FAIL single_idle_rspv got %b want %b", bus.rsp_valid, e.v);
      else pass_n++;
   endtask

   task automatic test_starve;
      logic [N-1:0] want;
      bus.req = 4'b1001;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         want = (k >= MW) ? 4'b1000 : 4'b0000;
         tot_n++;
         if (bus.starved !== want)
            $display("FAIL starve_rise k%0d got %b want %b", k, bus.starved, want);
         else pass_n++;
      end
      bus.req = '0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         tot_n++;
         if (bus.starved !== 4'b1000)
            $display("FAIL starve_hold k%0d got %b want 1000", k, bus.starved);
         else pass_n++;
      end
      bus.clr_starved = 1'b1;
      @(posedge clk); #1;
      bus.clr_starved = 1'b0;
      tot_n++;
      if (bus.starved !== 4'b0000)
         $display("FAIL starve_clr got %b want 0000", bus.starved);
      else pass_n++;
   endtask

   task automatic test_clr_vs_set;
      bus.req = 4'b1001;
      for (int k = 1; k <= MW - 1; k++) begin
         @(posedge clk); #1;
         tot_n++;
         if (bus.starved !== 4'b0000)
            $display("FAIL clrset_pre k%0d got %b want 0000", k, bus.starved);
         else pass_n++;
      end
      bus.clr_starved = 1'b1;
      @(posedge clk); #1;
      tot_n++;
      if (bus.starved !== 4'b1000)
         $display("FAIL clrset_win got %b want 1000", bus.starved);
      else pass_n++;
      bus.req = '0;
      @(posedge clk); #1;
      bus.clr_starved = 1'b0;
      tot_n++;
      if (bus.starved !== 4'b0000)
         $display("FAIL clrset_after got %b want 0000", bus.starved);
      else pass_n++;
   endtask

   task automatic test_reset_mid;
      bus.req = 4'b0010;
      @(posedge clk); #1;
      bus.req = '0;
      tot_n++;
      if (bus.rsp_valid !== 4'b0010)
         $display("FAIL rmid_pre got %b want 0010", bus.rsp_valid);
      else pass_n++;
      #1 rst_n = 1'b0;
      #1;
      tot_n++;
      if (bus.rsp_valid !== 4'b0000)
         $display("FAIL rmid_async got %b want 0000", bus.rsp_valid);
      else pass_n++;
      @(posedge clk); #2;
      rst_n = 1'b1;
      bus.req = 4'b1110;
      #1;
      tot_n++;
      if (bus.gnt !== 4'b0010)
         $display("FAIL rmid_ptr got %b want 0010", bus.gnt);
      else pass_n++;
      @(posedge clk); #1;
      bus.req = '0;
      tot_n++;
      if (bus.rsp_valid !== 4'b0010)
         $display("FAIL rmid_rspv got %b want 0010", bus.rsp_valid);
      else pass_n++;
      tot_n++;
      if (bus.rsp_data !== rom_fn(addr_tbl[1]))
         $display("FAIL rmid_data got %h want %h", bus.rsp_data,
                  rom_fn(addr_tbl[1]));
      else pass_n++;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_starve();
      test_clr_vs_set();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares a single negedge-clocked sprite ROM among several requesters on the VGA pixel clock. Requester 0 is the live pixel pipeline and has absolute priority. Requesters 1..N_REQ-1 (sprite loaders, collision probes, score overlay) share the remaining slots round-robin. The block sits between the requesters and one sprite ROM/palette pair, returns each ROM word to the requester that issued it, and flags low-priority starvation.

## Interface
- N_REQ, 4: number of requesters, 2..8; index 0 is the priority requester.
- ADDR_W, 12: ROM address width.
- DATA_W, 5: ROM word (palette index) width.
- MAX_WAIT, 64: wait-cycle threshold that sets a starvation flag, 1..255.
- vga_clk  in  1  single clock; all state on posedge. The ROM samples its address on negedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request, held until granted.
- req_addr  in  N_REQ x ADDR_W  per-requester address; stable while req is high.
- gnt  out  N_REQ  one-hot or zero; combinational grant in the current cycle.
- rom_address  out  ADDR_W  address to the ROM; the granted requester's address, else 0.
- rom_q  in  DATA_W  ROM data, valid from the posedge following the grant cycle.
- rsp_valid  out  N_REQ  registered one-hot; response for the requester granted in the previous cycle.
- rsp_data  out  DATA_W  equals rom_q; meaningful only while rsp_valid is nonzero.
- starved  out  N_REQ  sticky per-requester flag; bit 0 is always 0.
- clr_starved  in  1  synchronous clear of all starved bits.

## Operation
- Grant each cycle:
  - If req[0] is high, gnt[0] is high.
  - Otherwise the first set bit of req[1..N_REQ-1] at or after rr_ptr is granted, wrapping from N_REQ-1 to 1.
  - Otherwise gnt is 0.
- rr_ptr moves to (granted index + 1), wrapping to 1, only when a low-priority requester is granted. A grant to requester 0 or an idle cycle leaves it unchanged.
- A requester sees gnt for exactly one cycle per access. It may keep req high for back-to-back accesses, and may change req_addr in the cycle after gnt.
- rsp_valid at posedge t+1 equals gnt at cycle t. rsp_data is a combinational pass-through of rom_q.
- Wait counters, one per low-priority requester, 8 bits, saturating at 255:
  - increment each cycle the requester's req is high and gnt is low;
  - reset to 0 on grant or when req is low.
- starved[i] sets when wait[i] reaches MAX_WAIT and stays set until clr_starved or reset.
  - If clr_starved and the set condition occur in the same cycle, set wins.
- Reset values: rr_ptr=1, all wait counters 0, rsp_valid=0, starved=0.
  - gnt and rom_address are combinational, so they are 0 while all req are low.
- Reset asserted mid-access: rsp_valid clears immediately (asynchronously). The in-flight ROM word is discarded with no replay; the requester must re-request.

## Timing
- Grant latency: 0 cycles, combinational from req.
- Data latency: 1 cycle. Address is driven in cycle t, the ROM samples it at negedge t, and data plus rsp_valid are present from posedge t+1.
- Throughput: one access per cycle, fully pipelined.
- If req[0] stays high continuously, low-priority requesters are never granted. Their wait counters saturate and starved flags set, which is the intended diagnostic.
- Combinational path req → gnt → rom_address must meet half a vga_clk period, because the ROM samples on negedge.

## Structure
- Package sprite_arb_pkg holds:
  - N_REQ, ADDR_W, DATA_W and MAX_WAIT defaults;
  - typedef req_id_t (logic [$clog2(N_REQ)-1:0]);
  - typedef rom_addr_t.
- Sub-module rr_pick: a combinational round-robin first-set finder. Inputs are the request vector and the pointer; outputs are a one-hot grant and an index. It is reused by future arbiters.
- Top level contains the priority override, the address mux, the rr_ptr register, the wait counters, the starvation flags and the rsp_valid register.

## Test plan
- Reset then idle, N_REQ=4: gnt=0, rom_address=0, rsp_valid=0 and starved=0 for 10 cycles.
- req=4'b1111 held for 6 cycles, req[0] dropped after cycle 2:
  - grants are 0, 0, 1, 2, 3, 1;
  - rsp_valid follows one cycle later;
  - rsp_data matches a ROM model at each address.
- req_addr[2]=12'h0A5, req=4'b0100 for one cycle: gnt=4'b0100 and rom_address=12'h0A5; next posedge rsp_valid=4'b0100 and rsp_data=ROM[0x0A5].
- MAX_WAIT=8, req[0] and req[3] held high for 9 cycles:
  - starved[3] rises at the cycle wait[3]=8;
  - it stays high after req drops;
  - it clears on clr_starved.
- reset_n pulsed low mid-stream with rsp_valid=4'b0010: rsp_valid drops immediately; after release, rr_ptr=1 and req=4'b1110 grants 1 first.
- Same-cycle clr_starved and threshold reached: starved bit ends at 1.
